// File: rtl/display_scan_controller.sv
// Scan controller for common-anode seven-segment digits sharing one registered BCD decoder.
// Double-buffered value, blanking guard per slot, optional leading-zero suppression.
module display_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [4*NUM_DIGITS-1:0]       Value,
    input  logic                          Load,
    input  logic                          LZBlank,
    output logic [3:0]                    BCD,
    output logic [NUM_DIGITS-1:0]         Anodes,
    output logic [$clog2(NUM_DIGITS)-1:0] DigitIdx,
    output logic                          FrameUpdate
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {StBlank, StDrive} phase_e;

    phase_e                       phase_q, phase_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
    logic                         pending_q, pending_d;
    logic                         boundary;
    logic                         update_d;
    logic                         zero_run;
    logic [NUM_DIGITS-1:0]        suppress;
    logic [NUM_DIGITS-1:0]        anodes_d;
    logic [3:0]                   bcd_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        phase_d = phase_q;
        unique case (phase_q)
            StBlank: if (cnt_d == BLANK_END) phase_d = StDrive;
            StDrive: if (cnt_d == '0) phase_d = StBlank;
            default: phase_d = StBlank;
        endcase

        // A Load coinciding with the boundary supersedes whatever was pending.
        boundary  = (cnt_q == '0) && (idx_q == '0);
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        update_d  = 1'b0;
        if (boundary) begin
            if (Load) begin
                shadow_d  = Value;
                disp_d    = Value;
                pending_d = 1'b0;
                update_d  = 1'b1;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
                update_d  = 1'b1;
            end
        end else if (Load) begin
            shadow_d  = Value;
            pending_d = 1'b1;
        end

        zero_run = 1'b1;
        suppress = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_d[i] == 4'd0);
            if (i > 0) suppress[i] = zero_run;
        end

        // Suppressed digits still consume their slot so brightness stays uniform.
        anodes_d = '1;
        if (phase_d == StDrive && !(LZBlank && suppress[idx_d])) begin
            anodes_d[idx_d] = 1'b0;
        end

        bcd_d = disp_d[idx_d];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase_q     <= StBlank;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            disp_q      <= '0;
            pending_q   <= 1'b0;
            BCD         <= 4'd0;
            Anodes      <= '1;
            DigitIdx    <= '0;
            FrameUpdate <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            BCD         <= bcd_d;
            Anodes      <= anodes_d;
            DigitIdx    <= idx_d;
            FrameUpdate <= update_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_controller;

    logic        Clk;
    logic        Rst;
    logic [15:0] Value;
    logic        Load;
    logic        LZBlank;
    logic [3:0]  BCD;
    logic [3:0]  Anodes;
    logic [1:0]  DigitIdx;
    logic        FrameUpdate;

    int n_checks = 0;
    int n_fail   = 0;
    int bcnt     = 0;
    int bidx     = 0;
    bit chk_en   = 0;

    display_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Value      (Value),
        .Load       (Load),
        .LZBlank    (LZBlank),
        .BCD        (BCD),
        .Anodes     (Anodes),
        .DigitIdx   (DigitIdx),
        .FrameUpdate(FrameUpdate)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference slot position: cnt 0..7, idx 0..3.
    always @(posedge Clk) begin
        if (Rst) begin
            bcnt <= 0;
            bidx <= 0;
        end else if (bcnt == 7) begin
            bcnt <= 0;
            bidx <= (bidx == 3) ? 0 : bidx + 1;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            n_checks++;
            assert ($countones(~Anodes) <= 1 && (bcnt >= 2 || Anodes == 4'hF)) else begin
                n_fail++;
                $error("FAIL anode_excl: observed Anodes=%b at cnt=%0d, required at most one low and none low before cnt=2",
                       Anodes, bcnt);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h (idx=%0d cnt=%0d)", tag, obs, exp, bidx, bcnt);
        end
    endtask

    task automatic goto(input int i, input int c);
        for (int n = 0; n < 64; n++) begin
            if (bidx == i && bcnt == c) break;
            tick();
        end
    endtask

    // One full frame from the current position; no transfer may occur inside it.
    task automatic scan_frame(input logic [15:0] disp, input logic [3:0] mask, input string tag);
        logic [3:0] exp_an;
        for (int k = 0; k < 32; k++) begin
            exp_an = 4'hF;
            if (bcnt >= 2 && mask[bidx]) exp_an[bidx] = 1'b0;
            check({tag, "_anodes"}, 32'(Anodes), 32'(exp_an));
            check({tag, "_bcd"}, 32'(BCD), 32'(disp[bidx*4 +: 4]));
            check({tag, "_idx"}, 32'(DigitIdx), 32'(bidx));
            check({tag, "_fu"}, 32'(FrameUpdate), 32'd0);
            tick();
        end
    endtask

    initial begin
        Rst = 1'b1; Load = 1'b0; Value = 16'h0; LZBlank = 1'b0;
        repeat (3) tick();
        check("rst_anodes", 32'(Anodes), 32'hF);
        check("rst_bcd", 32'(BCD), 32'h0);
        check("rst_idx", 32'(DigitIdx), 32'h0);
        check("rst_fu", 32'(FrameUpdate), 32'h0);
        chk_en = 1'b1;

        // Reset/scan: load at the very first frame boundary.
        Rst = 1'b0; Load = 1'b1; Value = 16'h4321;
        tick();
        Load = 1'b0;
        check("scan_fu", 32'(FrameUpdate), 32'h1);
        check("scan_bcd0", 32'(BCD), 32'h1);
        check("scan_blank0", 32'(Anodes), 32'hF);
        tick();
        scan_frame(16'h4321, 4'hF, "scan");

        // Tear-free update.
        goto(1, 3);
        Load = 1'b1; Value = 16'h9999;
        tick();
        Load = 1'b0;
        goto(2, 1);
        check("tear_d2_old", 32'(BCD), 32'h3);
        goto(3, 1);
        check("tear_d3_old", 32'(BCD), 32'h4);
        goto(0, 0);
        check("tear_fu_early", 32'(FrameUpdate), 32'h0);
        tick();
        check("tear_fu", 32'(FrameUpdate), 32'h1);
        check("tear_bcd_new", 32'(BCD), 32'h9);
        tick();
        scan_frame(16'h9999, 4'hF, "tear");

        // Leading-zero suppression.
        LZBlank = 1'b1;
        goto(0, 3);
        Load = 1'b1; Value = 16'h0050;
        tick();
        Load = 1'b0;
        goto(0, 1);
        check("lz50_fu", 32'(FrameUpdate), 32'h1);
        tick();
        scan_frame(16'h0050, 4'b0011, "lz50");
        Load = 1'b1; Value = 16'h0000;
        tick();
        Load = 1'b0;
        goto(0, 1);
        check("lz0_fu", 32'(FrameUpdate), 32'h1);
        tick();
        scan_frame(16'h0000, 4'b0001, "lz0");
        LZBlank = 1'b0;
        scan_frame(16'h0000, 4'hF, "nolz");

        // Boundary collision: Load at the boundary overrides the pending value.
        Load = 1'b1; Value = 16'h5678;
        tick();
        Load = 1'b0;
        goto(0, 0);
        Load = 1'b1; Value = 16'h1234;
        tick();
        Load = 1'b0;
        check("coll_fu", 32'(FrameUpdate), 32'h1);
        check("coll_bcd", 32'(BCD), 32'h4);
        tick();
        scan_frame(16'h1234, 4'hF, "coll");

        // Back-to-back loads mid-frame: last one wins.
        goto(1, 5);
        Load = 1'b1; Value = 16'h1111;
        tick();
        Value = 16'h2222;
        tick();
        Load = 1'b0;
        goto(0, 1);
        check("b2b_fu", 32'(FrameUpdate), 32'h1);
        check("b2b_bcd", 32'(BCD), 32'h2);
        tick();
        scan_frame(16'h2222, 4'hF, "b2b");

        // Reset mid-operation discards a pending update.
        goto(1, 0);
        Load = 1'b1; Value = 16'h3333;
        tick();
        Load = 1'b0;
        goto(2, 5);
        Rst = 1'b1;
        tick();
        check("mrst_anodes", 32'(Anodes), 32'hF);
        check("mrst_bcd", 32'(BCD), 32'h0);
        check("mrst_idx", 32'(DigitIdx), 32'h0);
        check("mrst_fu", 32'(FrameUpdate), 32'h0);
        Rst = 1'b0;
        tick();
        check("mrst_fu_lost", 32'(FrameUpdate), 32'h0);
        check("mrst_bcd_lost", 32'(BCD), 32'h0);
        tick();
        scan_frame(16'h0000, 4'hF, "mrst");

        // Random loads over three frames; the negedge checker guards exclusivity.
        for (int k = 0; k < 96; k++) begin
            Load    = ($urandom_range(0, 3) == 0);
            Value   = 16'($urandom);
            LZBlank = 1'($urandom_range(0, 1));
            tick();
        end
        Load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
